// File: rtl/prio_enc_seq_if.sv
// Request-vector input handshake and index output handshake for prio_enc_seq.
// The encoder connects through the slave modport; the producer/consumer side uses master.
interface prio_enc_seq_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             none;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_idx, out_valid, out_last, none
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_idx, out_valid, out_last, none
    );
endinterface

// File: rtl/prio_enc_seq.sv
// Sequential priority encoder: accepts a request vector, then emits the index of
// every set bit, one per accepted beat, in MSB-first or LSB-first order.
module prio_enc_seq #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    prio_enc_seq_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_next;
    logic             none_q;
    logic             none_next;
    logic [IDX_W-1:0] idx;
    logic             single;

    // Later matches overwrite earlier ones, so scan direction selects the priority.
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (MSB_FIRST) begin
                if (pending[i]) idx = IDX_W'(i);
            end else begin
                if (pending[WIDTH-1-i]) idx = IDX_W'(WIDTH - 1 - i);
            end
        end
    end

    assign single = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

    always_comb begin
        state_next   = state;
        pending_next = pending;
        none_next    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_data != '0) begin
                        pending_next = bus.in_data;
                        state_next   = SCAN;
                    end else begin
                        none_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.out_ready) begin
                    pending_next[idx] = 1'b0;
                    if (single) state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            none_q  <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            none_q  <= none_next;
        end
    end

    // rst_n gating keeps in_ready low for the whole reset interval even though IDLE is the reset state.
    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == SCAN);
    assign bus.out_idx   = idx;
    assign bus.out_last  = (state == SCAN) && single;
    assign bus.none      = none_q;
endmodule

// File: tb/tb_prio_enc_seq.sv
// Self-checking bench: two 8-bit encoders (MSB/LSB first) in lockstep plus a 12-bit one,
// compared against expected index queues built from the set bits of each vector.
module tb_prio_enc_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    prio_enc_seq_if #(.WIDTH(8))  bm ();
    prio_enc_seq_if #(.WIDTH(8))  bl ();
    prio_enc_seq_if #(.WIDTH(12)) bc ();

    prio_enc_seq #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bm));
    prio_enc_seq #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bl));
    prio_enc_seq #(.WIDTH(12), .MSB_FIRST(1'b1)) u_w12 (.clk(clk), .rst_n(rst_n), .bus(bc));

    int qm[$];
    int ql[$];
    int qc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random out_ready, 1: always ready, 2: stall three cycles then ready
    task automatic run8(input logic [7:0] v, input int mode);
        int cyc;
        bit rdy;
        chk1("idle_in_ready_m", bm.in_ready, 1'b1);
        chk1("idle_in_ready_l", bl.in_ready, 1'b1);
        bm.in_data = v;    bl.in_data = v;
        bm.in_valid = 1'b1; bl.in_valid = 1'b1;
        tick();
        bm.in_valid = 1'b0; bl.in_valid = 1'b0;
        if (v == 8'h00) begin
            chk1("zero_none_m", bm.none, 1'b1);
            chk1("zero_none_l", bl.none, 1'b1);
            chk1("zero_valid_m", bm.out_valid, 1'b0);
            chk1("zero_in_ready_m", bm.in_ready, 1'b1);
            tick();
            chk1("zero_none_drop_m", bm.none, 1'b0);
            chk1("zero_none_drop_l", bl.none, 1'b0);
            chk1("zero_valid_after_m", bm.out_valid, 1'b0);
            return;
        end
        qm.delete();
        ql.delete();
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                ql.push_back(i);
                qm.push_front(i);
            end
        end
        cyc = 0;
        while (qm.size() > 0 && cyc < 64) begin
            rdy = (mode == 1) || (mode == 0 && ($urandom % 4) != 0) || (mode == 2 && cyc >= 3) || cyc >= 40;
            bm.out_ready = rdy; bl.out_ready = rdy;
            bm.in_valid = !(rdy && qm.size() == 1);
            bl.in_valid = bm.in_valid;
            bm.in_data  = (mode == 2) ? 8'hFF : 8'($urandom);
            bl.in_data  = bm.in_data;
            chk1("scan_valid_m", bm.out_valid, 1'b1);
            chk1("scan_valid_l", bl.out_valid, 1'b1);
            chk("scan_idx_m", 32'(bm.out_idx), qm[0]);
            chk("scan_idx_l", 32'(bl.out_idx), ql[0]);
            chk1("scan_last_m", bm.out_last, qm.size() == 1);
            chk1("scan_last_l", bl.out_last, ql.size() == 1);
            chk1("scan_in_ready_m", bm.in_ready, 1'b0);
            chk1("scan_none_m", bm.none, 1'b0);
            tick();
            if (rdy) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            cyc++;
        end
        chk("drain_budget", 32'(qm.size()), 0);
        bm.in_valid = 1'b0; bl.in_valid = 1'b0;
        bm.out_ready = 1'b0; bl.out_ready = 1'b0;
        chk1("done_valid_m", bm.out_valid, 1'b0);
        chk1("done_valid_l", bl.out_valid, 1'b0);
        chk1("done_in_ready_m", bm.in_ready, 1'b1);
        chk1("done_in_ready_l", bl.in_ready, 1'b1);
    endtask

    task automatic run12(input logic [11:0] v, input bit rand_ready);
        int cyc;
        bit rdy;
        chk1("w12_in_ready", bc.in_ready, 1'b1);
        bc.in_data  = v;
        bc.in_valid = 1'b1;
        tick();
        bc.in_valid = 1'b0;
        if (v == 12'h000) begin
            chk1("w12_none", bc.none, 1'b1);
            tick();
            return;
        end
        qc.delete();
        for (int i = 0; i < 12; i++) begin
            if (v[i]) qc.push_front(i);
        end
        cyc = 0;
        while (qc.size() > 0 && cyc < 64) begin
            rdy = !rand_ready || ($urandom % 3) != 0 || cyc >= 40;
            bc.out_ready = rdy;
            chk1("w12_valid", bc.out_valid, 1'b1);
            chk("w12_idx", 32'(bc.out_idx), qc[0]);
            chk1("w12_last", bc.out_last, qc.size() == 1);
            tick();
            if (rdy) void'(qc.pop_front());
            cyc++;
        end
        chk("w12_drain_budget", 32'(qc.size()), 0);
        bc.out_ready = 1'b0;
        chk1("w12_done_valid", bc.out_valid, 1'b0);
        chk1("w12_done_in_ready", bc.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bm.in_data = '0; bm.in_valid = 1'b0; bm.out_ready = 1'b0;
        bl.in_data = '0; bl.in_valid = 1'b0; bl.out_ready = 1'b0;
        bc.in_data = '0; bc.in_valid = 1'b0; bc.out_ready = 1'b0;

        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk1("rst_in_ready", bm.in_ready, 1'b0);
        chk1("rst_valid", bm.out_valid, 1'b0);
        chk("rst_idx", 32'(bm.out_idx), 0);
        chk1("rst_last", bm.out_last, 1'b0);
        chk1("rst_none", bm.none, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        run8(8'b1010_0101, 1);
        run8(8'h00, 1);
        run8(8'h90, 2);
        run12(12'h801, 1'b0);

        // reset in the middle of a scan
        bm.in_data = 8'hFF; bl.in_data = 8'hFF;
        bm.in_valid = 1'b1; bl.in_valid = 1'b1;
        tick();
        bm.in_valid = 1'b0; bl.in_valid = 1'b0;
        bm.out_ready = 1'b1; bl.out_ready = 1'b1;
        tick();
        tick();
        chk("mid_idx_m", 32'(bm.out_idx), 5);
        chk("mid_idx_l", 32'(bl.out_idx), 2);
        #2 rst_n = 1'b0;
        #1;
        chk1("scanrst_valid_m", bm.out_valid, 1'b0);
        chk1("scanrst_valid_l", bl.out_valid, 1'b0);
        chk1("scanrst_in_ready", bm.in_ready, 1'b0);
        chk("scanrst_idx", 32'(bm.out_idx), 0);
        chk1("scanrst_last", bm.out_last, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk1("post_rst_valid", bm.out_valid, 1'b0);
        run8(8'h02, 1);

        for (int n = 0; n < 30; n++) begin
            run8((($urandom % 6) == 0) ? 8'h00 : 8'($urandom), 0);
        end
        for (int n = 0; n < 10; n++) begin
            run12(12'($urandom), 1'b1);
        end
        run12(12'h000, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/prio_enc_seq.md
Name: prio_enc_seq

Overview:
Parametrised sequential priority encoder, successor to the fixed 8-bit combinational priority encoder. Captures a WIDTH-bit request vector through a valid/ready input handshake, then emits the index of every set bit, one per accepted output beat, in priority order. It sits between request-collecting logic and a consumer that services one request index at a time.

Parameters:
WIDTH, 8, request vector width; legal range 2..256.
MSB_FIRST, 1, 1 = highest set index emitted first; 0 = lowest set index emitted first.
IDX_W, $clog2(WIDTH), localparam; index width, not overridable.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  request vector, bit i = request i
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a vector
out_idx  output  IDX_W  index of the current highest-priority pending bit
out_valid  output  1  out_idx valid
out_ready  input  1  consumer accepts out_idx
out_last  output  1  current out_idx is the final pending bit of the vector
none  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Reset: asynchronous on rst_n low, regardless of clk. Clears the pending register, state = IDLE, out_valid = 0, out_idx = 0, out_last = 0, none = 0, in_ready = 0 while rst_n is low. After release, in_ready = 1 from the first cycle.
- States: IDLE and SCAN. All outputs are decoded from registers; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On a clock edge with in_valid = 1 and in_data != 0: load in_data into the pending register and go to SCAN.
  - On a clock edge with in_valid = 1 and in_data == 0: stay in IDLE; none = 1 for exactly the next cycle. No out beat is produced.
- SCAN:
  - in_ready = 0; in_valid is ignored, and no vector is queued.
  - out_valid = 1.
  - out_idx = priority encode of the pending register: MSB-first when MSB_FIRST = 1, LSB-first otherwise.
  - out_last = 1 iff exactly one pending bit is set.
- Beat: out_valid && out_ready at a clock edge.
  - Clears the pending bit at out_idx.
  - If out_last = 1, go to IDLE; in_ready rises in the next cycle.
- Latency and throughput:
  - First out_valid appears one cycle after the input-accept edge.
  - One index per cycle while out_ready = 1.
  - A vector with k set bits occupies SCAN for at least k cycles. The next vector is accepted no earlier than the cycle after the last beat.
- Backpressure: while out_ready = 0, out_idx, out_valid and out_last stay stable, and the pending register is unchanged.
- Width rules:
  - out_idx is zero-extended into IDX_W.
  - For non-power-of-two WIDTH, indices at or above WIDTH never occur.
- Reset during SCAN: remaining pending bits are discarded, with no partial beat. The block returns to IDLE per the reset values.
- Simultaneous events: none is not asserted together with out_valid, because none only occurs from IDLE.

Test Plan:
1. WIDTH = 8, MSB_FIRST = 1, in_data = 8'b1010_0101 accepted, out_ready held 1 -> out_idx = 7, 5, 2, 0 on four consecutive cycles; out_last = 1 only with idx 0; in_ready = 1 on the cycle after.
2. Same vector with MSB_FIRST = 0 -> out_idx = 0, 2, 5, 7; out_last with 7.
3. in_data = 8'h00 accepted -> none = 1 for exactly 1 cycle, out_valid stays 0, in_ready stays 1.
4. in_data = 8'h90, out_ready = 0 for 3 cycles, then 1 -> out_idx holds 7 with out_valid = 1 for 3 cycles, then 7, 4; in_valid = 1 with 8'hFF during SCAN is not accepted (in_ready = 0).
5. WIDTH = 12 (IDX_W = 4), in_data = 12'h801 -> out_idx = 11 then 0.
6. in_data = 8'hFF, rst_n driven low asynchronously after 2 beats -> out_valid drops immediately. After release, in_ready = 1 and a new vector 8'h02 yields a single beat, out_idx = 1, out_last = 1.
